// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control-unit <-> datapath/memory signal bundle
interface mc_control_fsm_if;
  // Status returned by the datapath and memory
  logic [15:0] instr;
  logic        zero;
  logic        mem_ready;

  // Memory handshake
  logic        mem_req;
  logic        mem_we;
  logic        iord;

  // Datapath register enables and operand selects
  logic        ir_we;
  logic        mdr_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        b_sel;
  logic        rf_we;
  logic        rf_wsel;

  // Status
  logic        halted;
  logic [15:0] retired;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pc_src,
           alu_src_a, alu_src_b, alu_op, b_sel, rf_we, rf_wsel,
           halted, retired
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pc_src,
           alu_src_a, alu_src_b, alu_op, b_sel, rf_we, rf_wsel,
           halted, retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle control unit for the 16-bit processor
module mc_control_fsm #(
  parameter logic [2:0]  ALU_ADD       = 3'd3,
  parameter logic [2:0]  ALU_SUB       = 3'd4,
  // Value loaded into the retired-instruction counter on reset
  parameter logic [15:0] RETIRED_RESET = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB_ALU,
    S_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  // Registered control word. The *_on_ready / *_on_zero bits are qualifiers
  // that are ANDed with the live mem_ready / zero inputs, which keeps those
  // enables same-cycle (Mealy) while everything else comes from flops.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_on_ready;
    logic       mdr_on_ready;
    logic       pc_on_ready;
    logic       pc_on_zero;
    logic       pc_always;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       rf_we;
    logic       rf_wsel;
    logic       halted;
  } ctrl_t;

  state_t      state;
  state_t      state_next;
  ctrl_t       ctrl_q;
  logic [15:0] retired_q;
  logic        retire;
  logic [3:0]  op;
  logic        unused_instr_bits;

  assign op                = bus.instr[15:12];
  assign unused_instr_bits = ^bus.instr[11:0];

  // Control word for a given state; only fields that differ from 0 are set.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req     = 1'b1;
        c.alu_src_b   = 2'd1;
        c.alu_op      = ALU_ADD;
        c.ir_on_ready = 1'b1;
        c.pc_on_ready = 1'b1;
      end
      S_DECODE: begin
        // ALUOut <= PC + sext(imm4), the branch target
        c.alu_src_b = 2'd3;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ir[14:12];
      end
      S_WB_ALU: begin
        c.rf_we = 1'b1;
      end
      S_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_req      = 1'b1;
        c.iord         = 1'b1;
        c.mdr_on_ready = 1'b1;
      end
      S_WB_MEM: begin
        c.rf_we   = 1'b1;
        c.rf_wsel = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      S_BRANCH: begin
        // A - B compare; the ALU zero flag decides whether PC takes ALUOut
        c.alu_src_a  = 1'b1;
        c.alu_op     = ALU_SUB;
        c.pc_src     = 2'd1;
        c.pc_on_zero = 1'b1;
      end
      S_JUMP: begin
        c.pc_always = 1'b1;
        c.pc_src    = 2'd2;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next-state selection and retirement detection
  always_comb begin
    state_next = state;
    case (state)
      S_START:  state_next = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (!op[3]) begin
          state_next = S_EXEC;
        end else begin
          case (op[2:0])
            3'd0, 3'd1: state_next = S_ADDR;
            3'd2:       state_next = S_BRANCH;
            3'd3:       state_next = S_JUMP;
            3'd7:       state_next = S_HALT;
            default:    state_next = S_FETCH;
          endcase
        end
      end
      S_EXEC:   state_next = S_WB_ALU;
      S_WB_ALU: state_next = S_FETCH;
      S_ADDR:   state_next = (op == 4'h8) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (bus.mem_ready) state_next = S_WB_MEM;
      S_WB_MEM: state_next = S_FETCH;
      S_MEM_WR: if (bus.mem_ready) state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_START;
    endcase
    // An instruction retires when control re-enters FETCH from its last state
    retire = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_START);
  end

  // State, registered control word and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_START;
      ctrl_q    <= '0;
      retired_q <= RETIRED_RESET;
    end else begin
      state  <= state_next;
      ctrl_q <= ctrl_for(state_next, bus.instr);
      if (retire) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  assign bus.mem_req   = ctrl_q.mem_req;
  assign bus.mem_we    = ctrl_q.mem_we;
  assign bus.iord      = ctrl_q.iord;
  assign bus.ir_we     = ctrl_q.ir_on_ready & bus.mem_ready;
  assign bus.mdr_we    = ctrl_q.mdr_on_ready & bus.mem_ready;
  assign bus.pc_we     = ctrl_q.pc_always
                       | (ctrl_q.pc_on_ready & bus.mem_ready)
                       | (ctrl_q.pc_on_zero & bus.zero);
  assign bus.pc_src    = ctrl_q.pc_src;
  assign bus.alu_src_a = ctrl_q.alu_src_a;
  assign bus.alu_src_b = ctrl_q.alu_src_b;
  assign bus.alu_op    = ctrl_q.alu_op;
  assign bus.rf_we     = ctrl_q.rf_we;
  assign bus.rf_wsel   = ctrl_q.rf_wsel;
  assign bus.halted    = ctrl_q.halted;
  assign bus.retired   = retired_q;

  // SW and BEQ read R[rd] on port 2; held at 0 while reset forces START
  assign bus.b_sel = (state != S_START) && ((op == 4'h9) || (op == 4'hA));

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit for the 16-bit processor.
- Sequences the shared ALU, register file, PC/IR/MDR/ALUOut registers and unified memory through fetch/decode/execute/memory/writeback states.
- Drives the ALU opcode and the operand-mux selects.
- Handshakes with memory via req/ready and counts retired instructions.

Parameters:
- ALU_ADD, 3'd3, ALUOp code for addition.
- ALU_SUB, 3'd4, ALUOp code for subtraction (BEQ compare).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  16  current IR contents: op[15:12], rd[11:8], rs[7:4], rt/imm4[3:0]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (valid with mem_req)
- iord  out  1  address select: 0=PC, 1=ALUOut
- ir_we  out  1  load IR from memory data
- mdr_we  out  1  load MDR from memory data
- pc_we  out  1  load PC
- pc_src  out  2  0=ALU result, 1=ALUOut, 2={PC[15:12],instr[11:0]}
- alu_src_a  out  1  0=PC, 1=A (R[rs])
- alu_src_b  out  2  0=B, 1=const 1, 2=zext imm4, 3=sext imm4
- alu_op  out  3  ALUOp to the ALU
- b_sel  out  1  register read port 2 address: 0=rt, 1=rd
- rf_we  out  1  register-file write to rd
- rf_wsel  out  1  write data: 0=ALUOut, 1=MDR
- halted  out  1  in HALT state
- retired  out  16  retired-instruction count

Behaviour:
- Clock and reset: one clock `clk`; `rst_n` is asynchronous, active-low.
- Reset:
  - state=START, retired=0.
  - All outputs 0 while rst_n low and in START (alu_op=0, b_sel=0).
  - Reset mid-operation aborts immediately; mem_req drops asynchronously.
- Output defaults: every output not listed for a state is 0. b_sel is combinational from instr: 1 for op 0x9/0xA, else 0.
- Opcodes:
  - 0x0-0x7: R-type, rd<=R[rs] op R[rt], alu_op=op[2:0]
  - 0x8 LW: rd<=M[R[rs]+zext imm4]
  - 0x9 SW: M[R[rs]+zext imm4]<=R[rd]
  - 0xA BEQ: if R[rs]==R[rd], PC<=PC+1+sext imm4
  - 0xB JMP
  - 0xC-0xE: NOP
  - 0xF: HALT
- States and transitions:
  - START: outputs 0; next FETCH.
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ALU_ADD, pc_src=0.
    - ir_we and pc_we = mem_ready (Mealy).
    - Stay until mem_ready, then DECODE.
  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=ALU_ADD (ALUOut <= branch target).
    - Next: EXEC for 0x0-7, ADDR for 0x8/0x9, BRANCH for 0xA, JUMP for 0xB, HALT for 0xF.
    - For 0xC-E, next is FETCH and retired increments.
  - EXEC: alu_src_a=1, alu_src_b=0, alu_op=instr[14:12]; next WB_ALU.
  - WB_ALU: rf_we=1, rf_wsel=0; next FETCH.
  - ADDR: alu_src_a=1, alu_src_b=2, alu_op=ALU_ADD; next MEM_RD (0x8) or MEM_WR (0x9).
  - MEM_RD: mem_req=1, iord=1, mdr_we=mem_ready; wait for mem_ready, then WB_MEM.
  - WB_MEM: rf_we=1, rf_wsel=1; next FETCH.
  - MEM_WR: mem_req=1, mem_we=1, iord=1; wait for mem_ready, then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=ALU_SUB, pc_src=1, pc_we=zero; next FETCH.
  - JUMP: pc_we=1, pc_src=2; next FETCH.
  - HALT: halted=1; stays until reset; mem_req=0.
- retired: +1 on every transition into FETCH from a state other than START; wraps FFFF->0000. HALT does not count.
- mem_ready: ignored when mem_req=0. Held high continuously gives zero-wait accesses.
- Latency with zero-wait memory, FETCH entry to next FETCH: R-type 4, LW 5, SW 4, BEQ 3, JMP 3, NOP 2. Each memory wait cycle adds 1.

Test Plan:
- Reset, rst_n low 3 cycles then high, mem_ready=1 -> all outputs 0 during reset and START; FETCH asserts mem_req=1, ir_we=1, pc_we=1, alu_op=3'd3.
- instr=16'h3123 (R-type op3), mem_ready=1 -> EXEC alu_op=3'd3, alu_src_a=1, alu_src_b=0; WB_ALU rf_we=1, rf_wsel=0; FETCH again 4 cycles after the first; retired 0->1.
- LW instr=16'h8125, mem_ready low 2 cycles in MEM_RD -> mem_req=1, iord=1 held 3 cycles; mdr_we=1 only in the ready cycle; WB_MEM rf_wsel=1; total 7 cycles.
- BEQ instr=16'hA12F: with zero=1 -> pc_we=1, pc_src=1 in BRANCH, alu_op=3'd4. Repeat with zero=0 -> pc_we=0; FETCH follows in both cases.
- SW instr=16'h9340 -> b_sel=1, mem_we=1 in MEM_WR. HALT instr=16'hF000 -> halted=1 held 10 cycles, mem_req=0, retired unchanged.
- Retired counter preloaded near FFFF via repeated NOP 16'hC000 -> wraps to 0000. rst_n low mid-MEM_RD -> mem_req drops asynchronously, state START, retired=0.
